// File: rtl/mioc_bus_pkg.sv
// rtl/mioc_bus_pkg.sv - shared bus-cycle state, request encodings and refresh helpers
package mioc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HOLD = 3'd6
  } bus_state_t;

  // req_kind encodings; 2'd3 is reserved and runs as a memory cycle
  localparam logic [1:0] KIND_MEM = 2'd0;
  localparam logic [1:0] KIND_IO  = 2'd1;
  localparam logic [1:0] KIND_M1  = 2'd2;

  // IO cycles always get this many wait states before WAIT_N is looked at
  localparam int IO_FORCED_WAITS = 1;

  // Z80 refresh counter: only the low seven bits count, bit 7 stays 0
  localparam int RFSH_W = 7;

  function automatic logic [15:0] rfsh_addr(input logic [RFSH_W-1:0] r);
    return {{(16 - RFSH_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/z80_wait_ctr.sv
// rtl/z80_wait_ctr.sv - consecutive wait-state counter with MAX_WAIT timeout flag
module z80_wait_ctr #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // count WAIT_N-requested wait states since the last T1
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  // the FSM never increments past the limit, so equality is enough
  assign timeout = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/z80_bus_master.sv
// rtl/z80_bus_master.sv - Z80-style bus-cycle initiator driving buffered-bus strobes
module z80_bus_master
  import mioc_bus_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        B_PHI,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] BA,
  output logic        BA_OE,
  output logic [7:0]  BD_OUT,
  output logic        BD_OE,
  input  logic [7:0]  BD_IN,
  output logic        BMREQ_N,
  output logic        IORQ_N,
  output logic        BRD_N,
  output logic        N_BWR,
  output logic        BM1_N,
  output logic        BRFSH_N,
  input  logic        WAIT_N,
  input  logic        BUSRQ_N,
  output logic        BUSAK_N
);

  bus_state_t state, state_d;

  logic [1:0]        kind_q;
  logic              write_q;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic              err_q;
  logic [7:0]        data_q;
  logic [RFSH_W-1:0] r_q;
  logic [1:0]        forced_cnt;

  logic accept;
  logic cyc_io, cyc_m1, cyc_wr;
  logic wait_inc, forced_inc, set_err, wait_timeout;
  logic [7:0] rd_cap;

  // request fields as they will be once this edge has latched them
  logic [1:0]  kind_n;
  logic        write_n;
  logic [15:0] addr_n;
  logic [7:0]  wdata_n;
  logic        n_io, n_m1, n_wr;

  logic [15:0] ba_d;
  logic [7:0]  bd_out_d, rsp_rdata_d;
  logic        ba_oe_d, bd_oe_d, busak_d, rsp_valid_d, rsp_err_d;
  logic        mreq_d, iorq_d, rd_d, wr_d, m1_d, rfsh_d;

  assign req_ready = RST_N && (state == ST_IDLE) && BUSRQ_N;
  assign accept    = req_valid && req_ready;

  assign cyc_io = (kind_q == KIND_IO);
  assign cyc_m1 = (kind_q == KIND_M1);
  assign cyc_wr = write_q && !cyc_m1;

  assign kind_n  = accept ? req_kind  : kind_q;
  assign write_n = accept ? req_write : write_q;
  assign addr_n  = accept ? req_addr  : addr_q;
  assign wdata_n = accept ? req_wdata : wdata_q;
  assign n_io    = (kind_n == KIND_IO);
  assign n_m1    = (kind_n == KIND_M1);
  assign n_wr    = write_n && !n_m1;

  // a timed-out read returns FF instead of whatever is floating on the bus
  assign rd_cap = cyc_wr ? 8'h00 : (err_q ? 8'hFF : BD_IN);

  z80_wait_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_ctr (
    .clk     (B_PHI),
    .rst_n   (RST_N),
    .clear   (state == ST_T1),
    .inc     (wait_inc),
    .timeout (wait_timeout)
  );

  // T-state register
  always_ff @(posedge B_PHI) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // next T-state; WAIT_N only matters on the edges leaving T2/TW
  always_comb begin
    state_d    = state;
    wait_inc   = 1'b0;
    forced_inc = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!BUSRQ_N) begin
          state_d = ST_HOLD;
        end else if (req_valid) begin
          state_d = ST_T1;
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2, ST_TW: begin
        if (cyc_io && (forced_cnt < 2'(IO_FORCED_WAITS))) begin
          state_d    = ST_TW;
          forced_inc = 1'b1;
        end else if (!WAIT_N) begin
          if (wait_timeout) begin
            state_d = ST_T3;
            set_err = 1'b1;
          end else begin
            state_d  = ST_TW;
            wait_inc = 1'b1;
          end
        end else begin
          state_d = ST_T3;
        end
      end
      ST_T3: begin
        if (cyc_m1) begin
          state_d = ST_T4;
        end else if (!BUSRQ_N) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T4: state_d = BUSRQ_N ? ST_IDLE : ST_HOLD;
      ST_HOLD: begin
        if (BUSRQ_N) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus output values for the T-state about to begin
  always_comb begin
    ba_d     = BA;
    ba_oe_d  = 1'b1;
    bd_out_d = BD_OUT;
    bd_oe_d  = 1'b0;
    mreq_d   = 1'b1;
    iorq_d   = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    m1_d     = 1'b1;
    rfsh_d   = 1'b1;
    busak_d  = 1'b1;
    case (state_d)
      ST_T1, ST_T2, ST_TW, ST_T3: begin
        ba_d    = addr_n;
        bd_oe_d = n_wr;
        if (n_wr) begin
          bd_out_d = wdata_n;
        end
        if (n_io) begin
          if (state_d != ST_T1) begin
            iorq_d = 1'b0;
            if (n_wr) begin
              wr_d = 1'b0;
            end else begin
              rd_d = 1'b0;
            end
          end
        end else begin
          mreq_d = 1'b0;
          if (n_m1) begin
            m1_d = 1'b0;
          end
          if (!n_wr) begin
            rd_d = 1'b0;
          end else if (state_d != ST_T1) begin
            wr_d = 1'b0;
          end
        end
      end
      ST_T4: begin
        ba_d   = rfsh_addr(r_q);
        mreq_d = 1'b0;
        rfsh_d = 1'b0;
      end
      ST_HOLD: begin
        ba_oe_d = 1'b0;
        busak_d = 1'b0;
      end
      default: ;
    endcase
  end

  // completion is reported on the edge leaving the last T-state
  always_comb begin
    rsp_valid_d = ((state == ST_T3) && !cyc_m1) || (state == ST_T4);
    rsp_err_d   = rsp_valid_d && err_q;
    rsp_rdata_d = rsp_rdata;
    if ((state == ST_T3) && !cyc_m1) begin
      rsp_rdata_d = rd_cap;
    end else if (state == ST_T4) begin
      rsp_rdata_d = data_q;
    end
  end

  // request latch, timeout flag, read capture and refresh counter
  always_ff @(posedge B_PHI) begin
    if (!RST_N) begin
      kind_q     <= KIND_MEM;
      write_q    <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      err_q      <= 1'b0;
      data_q     <= 8'h00;
      r_q        <= '0;
      forced_cnt <= 2'd0;
    end else begin
      if (accept) begin
        kind_q  <= req_kind;
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
      if (state == ST_T3) begin
        data_q <= rd_cap;
      end
      if (state == ST_T4) begin
        r_q <= r_q + RFSH_W'(1);
      end
      if (state == ST_T1) begin
        forced_cnt <= 2'd0;
      end else if (forced_inc) begin
        forced_cnt <= forced_cnt + 2'd1;
      end
    end
  end

  // registered bus strobes, drive enables and response
  always_ff @(posedge B_PHI) begin
    if (!RST_N) begin
      BA        <= 16'h0000;
      BA_OE     <= 1'b1;
      BD_OUT    <= 8'h00;
      BD_OE     <= 1'b0;
      BMREQ_N   <= 1'b1;
      IORQ_N    <= 1'b1;
      BRD_N     <= 1'b1;
      N_BWR     <= 1'b1;
      BM1_N     <= 1'b1;
      BRFSH_N   <= 1'b1;
      BUSAK_N   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      BA        <= ba_d;
      BA_OE     <= ba_oe_d;
      BD_OUT    <= bd_out_d;
      BD_OE     <= bd_oe_d;
      BMREQ_N   <= mreq_d;
      IORQ_N    <= iorq_d;
      BRD_N     <= rd_d;
      N_BWR     <= wr_d;
      BM1_N     <= m1_d;
      BRFSH_N   <= rfsh_d;
      BUSAK_N   <= busak_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// tb/tb_z80_bus_master.sv - randomized bench for z80_bus_master against a T-state sequence model
module tb_z80_bus_master;

  localparam int MAXW = 4;

  localparam int P_T1   = 1;
  localparam int P_T2   = 2;
  localparam int P_TW   = 3;
  localparam int P_T3   = 4;
  localparam int P_T4   = 5;
  localparam int P_IDLE = 6;
  localparam int P_HOLD = 7;

  logic        B_PHI = 1'b0;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] BA;
  logic        BA_OE;
  logic [7:0]  BD_OUT;
  logic        BD_OE;
  logic [7:0]  BD_IN;
  logic        BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N;
  logic        WAIT_N;
  logic        BUSRQ_N;
  logic        BUSAK_N;

  logic [9:0]  bus_vec;

  int checks  = 0;
  int errors  = 0;
  int r_model = 0;

  always #5 B_PHI = ~B_PHI;

  z80_bus_master #(
    .MAX_WAIT(MAXW)
  ) dut (
    .B_PHI     (B_PHI),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .BA        (BA),
    .BA_OE     (BA_OE),
    .BD_OUT    (BD_OUT),
    .BD_OE     (BD_OE),
    .BD_IN     (BD_IN),
    .BMREQ_N   (BMREQ_N),
    .IORQ_N    (IORQ_N),
    .BRD_N     (BRD_N),
    .N_BWR     (N_BWR),
    .BM1_N     (BM1_N),
    .BRFSH_N   (BRFSH_N),
    .WAIT_N    (WAIT_N),
    .BUSRQ_N   (BUSRQ_N),
    .BUSAK_N   (BUSAK_N)
  );

  assign bus_vec = {BA_OE, BD_OE, BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUSAK_N, rsp_valid};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {BA_OE,BD_OE,MREQ,IORQ,RD,WR,M1,RFSH,BUSAK,rsp_valid}; cls 0=mem 1=io 2=m1
  function automatic logic [9:0] exp_bus(input int ph, input int cls, input bit wr, input bit rv);
    logic oe, doe, mreq, iorq, rd, wrs, m1, rf, ak;
    bit   late;
    oe = 1'b1; doe = 1'b0; mreq = 1'b1; iorq = 1'b1; rd = 1'b1;
    wrs = 1'b1; m1 = 1'b1; rf = 1'b1; ak = 1'b1;
    late = (ph != P_T1);
    if (ph == P_T1 || ph == P_T2 || ph == P_TW || ph == P_T3) begin
      doe = wr;
      if (cls == 1) begin
        if (late) begin
          iorq = 1'b0;
          if (wr) wrs = 1'b0;
          else    rd  = 1'b0;
        end
      end else begin
        mreq = 1'b0;
        if (cls == 2) m1 = 1'b0;
        if (!wr) rd = 1'b0;
        else if (late) wrs = 1'b0;
      end
    end else if (ph == P_T4) begin
      mreq = 1'b0;
      rf   = 1'b0;
    end else if (ph == P_HOLD) begin
      oe = 1'b0;
      ak = 1'b0;
    end
    return {oe, doe, mreq, iorq, rd, wrs, m1, rf, ak, rv};
  endfunction

  // one bus transaction: nlow = WAIT_N-low samples, hold = HOLD cycles requested from T2,
  // abort_at = T-state index at which RST_N is pulsed (0 = never)
  task automatic run_txn(input logic [1:0] kind, input bit wr_in, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata, input int nlow,
                         input int hold, input int abort_at);
    int          ph_q[$];
    int          cls, first, tw, guard;
    bit          wr, err;
    logic [15:0] rf_addr;
    cls = (kind == 2'd1) ? 1 : (kind == 2'd2) ? 2 : 0;
    wr  = wr_in && (cls != 2);
    ph_q.push_back(P_T1);
    ph_q.push_back(P_T2);
    if (cls == 1) ph_q.push_back(P_TW);
    tw = (nlow > MAXW) ? MAXW : nlow;
    repeat (tw) ph_q.push_back(P_TW);
    ph_q.push_back(P_T3);
    if (cls == 2) ph_q.push_back(P_T4);
    err     = (nlow > MAXW);
    first   = (cls == 1) ? 3 : 2;
    rf_addr = 16'(r_model);

    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge B_PHI);
      guard++;
    end
    check("req_ready before accept", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_write = wr_in;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge B_PHI);

    for (int i = 1; i <= ph_q.size(); i++) begin
      int ph;
      ph        = ph_q[i-1];
      req_valid = 1'b0;
      req_kind  = 2'($urandom);
      req_write = 1'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      WAIT_N    = !((i >= first) && (i < first + nlow));
      BD_IN     = (ph == P_T3) ? rdata : 8'($urandom);
      if (hold > 0 && i >= 2) BUSRQ_N = 1'b0;
      check($sformatf("strobes phase %0d of kind %0d", ph, cls), 32'(bus_vec), 32'(exp_bus(ph, cls, wr, 1'b0)));
      if (ph == P_T4) check("refresh address", 32'(BA), 32'(rf_addr));
      else            check("address", 32'(BA), 32'(addr));
      if (wr) check("write data", 32'(BD_OUT), 32'(wdata));
      if (i == abort_at) begin
        RST_N = 1'b0;
        @(negedge B_PHI);
        check("strobes in reset", 32'(bus_vec), 32'(exp_bus(P_IDLE, 0, 1'b0, 1'b0)));
        check("BA in reset", 32'(BA), 0);
        check("rsp in reset", 32'({rsp_err, rsp_rdata}), 0);
        check("req_ready in reset", 32'(req_ready), 0);
        RST_N  = 1'b1;
        WAIT_N = 1'b1;
        @(negedge B_PHI);
        check("strobes after reset", 32'(bus_vec), 32'(exp_bus(P_IDLE, 0, 1'b0, 1'b0)));
        check("req_ready after reset", 32'(req_ready), 1);
        r_model = 0;
        return;
      end
      @(negedge B_PHI);
    end

    WAIT_N = 1'b1;
    check("completion strobes", 32'(bus_vec), 32'(exp_bus((hold > 0) ? P_HOLD : P_IDLE, 0, 1'b0, 1'b1)));
    check("rsp_err", 32'(rsp_err), 32'(err));
    if (!wr) check("rsp_rdata", 32'(rsp_rdata), err ? 32'hFF : 32'(rdata));
    if (cls == 2) r_model = (r_model + 1) % 128;
    if (hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        @(negedge B_PHI);
        check("hold strobes", 32'(bus_vec), 32'(exp_bus(P_HOLD, 0, 1'b0, 1'b0)));
        if (h == hold) BUSRQ_N = 1'b1;
      end
      @(negedge B_PHI);
      check("strobes after hold", 32'(bus_vec), 32'(exp_bus(P_IDLE, 0, 1'b0, 1'b0)));
    end else begin
      check("req_ready in rsp cycle", 32'(req_ready), 1);
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'd0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    BD_IN     = 8'h00;
    WAIT_N    = 1'b1;
    BUSRQ_N   = 1'b1;

    repeat (3) @(negedge B_PHI);
    check("reset strobes", 32'(bus_vec), 32'(exp_bus(P_IDLE, 0, 1'b0, 1'b0)));
    check("reset BA", 32'(BA), 0);
    check("reset rsp", 32'({rsp_err, rsp_rdata}), 0);
    check("reset req_ready", 32'(req_ready), 0);
    RST_N = 1'b1;
    @(negedge B_PHI);
    check("first idle req_ready", 32'(req_ready), 1);

    run_txn(2'd0, 1'b1, 16'h2000, 8'h5A, 8'h00, 0, 0, 0);
    run_txn(2'd0, 1'b0, 16'h4000, 8'h00, 8'hC3, 2, 0, 0);
    run_txn(2'd1, 1'b0, 16'h00C0, 8'h00, 8'h3C, 0, 0, 0);
    run_txn(2'd1, 1'b1, 16'h00C1, 8'hA5, 8'h00, 1, 0, 0);
    run_txn(2'd0, 1'b0, 16'h1234, 8'h00, 8'h77, 1000, 0, 0);
    run_txn(2'd0, 1'b1, 16'h8001, 8'h96, 8'h00, 0, 3, 0);
    run_txn(2'd3, 1'b0, 16'h0F0F, 8'h00, 8'h81, 3, 0, 4);

    while (r_model != 'h7C) begin
      run_txn(2'd2, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), 0, 0);
    end
    for (int n = 0; n < 8; n++) begin
      run_txn(2'd2, 1'b0, 16'($urandom), 8'h00, 8'($urandom), 0, 0, 0);
    end

    for (int n = 0; n < 60; n++) begin
      int nl, hd;
      nl = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      hd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn(2'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), nl, hd, 0);
      repeat ($urandom_range(0, 2)) @(negedge B_PHI);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
